core_if: RTL and testbench

CORE_IF -- requirements
Module: core_if

---
 rtl/i2d_core_defines.sv | 24 ++
 rtl/core_if.sv | 127 ++++++++++++
 tb/tb_core_if.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2d_core_defines.sv
// rtl/i2d_core_defines.sv - shared core definitions: instruction encoding and fetch FSM states
//
// Purpose: types and constants shared between the fetch stage and decode.
// Ports:   none (package).

package i2d_core_defines;

  // Major opcode lives in the top six bits of every instruction word.
  localparam logic [5:0] OPCODE_NOP = 6'h2A;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [25:0] operand;
  } instr_t;

  // Fetch FSM state encoding.
  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT,
    IF_DISCARD
  } if_state_t;

endpackage

// File: rtl/core_if.sv
// rtl/core_if.sv - instruction fetch stage with one-entry output slot and flush handling
//
// Purpose: fetches sequential instruction words over a single-cycle-ack instruction
//          bus and presents them to decode through a one-entry slot.
// Ports:   clk, rst (sync, active-high)
//          id_halt            - decode stall, slot not consumed
//          flush, branch_pc   - redirect fetch to branch_pc
//          ibus_req/addr      - instruction-bus request (word aligned)
//          ibus_ack/rdata     - accept strobe with same-cycle read data
//          if_pc/if_instr     - presented instruction and its address
//          if_busy            - 0 when the slot is valid and consumed this cycle

import i2d_core_defines::*;

module core_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_halt,
  input  logic        flush,
  input  logic [31:0] branch_pc,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_busy
);

  if_state_t   state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] dpc_q, dpc_d;     // address still on the bus while discarding
  logic [31:0] pc_q, pc_d;
  instr_t      instr_q, instr_d;
  logic        ov_q, ov_d;

  logic consume;
  logic slot_free;

  assign consume   = ov_q & ~id_halt;
  assign slot_free = ~ov_q | consume;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    dpc_d   = dpc_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ov_d    = ov_q;

    if (consume) begin
      ov_d = 1'b0;
    end

    if (flush) begin
      ov_d  = 1'b0;
      fpc_d = {branch_pc[31:2], 2'b00};
      case (state_q)
        // An unacked request must stay on the bus; remember its address.
        IF_REQ: begin
          if (!ibus_ack) begin
            state_d = IF_DISCARD;
            dpc_d   = fpc_q;
          end else begin
            state_d = IF_REQ;
          end
        end
        IF_DISCARD: state_d = ibus_ack ? IF_REQ : IF_DISCARD;
        default:    state_d = IF_REQ;
      endcase
    end else begin
      case (state_q)
        IF_IDLE: state_d = IF_REQ;
        IF_REQ: begin
          // A held, full slot cannot take the returning word: back off
          // and refetch the same address once decode drains the slot.
          if (!slot_free) begin
            state_d = IF_WAIT;
          end else if (ibus_ack) begin
            pc_d    = fpc_q;
            instr_d = instr_t'(ibus_rdata);
            ov_d    = 1'b1;
            fpc_d   = fpc_q + 32'd4;
          end
        end
        IF_WAIT: begin
          if (consume) begin
            state_d = IF_REQ;
          end
        end
        IF_DISCARD: begin
          if (ibus_ack) begin
            state_d = IF_REQ;
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_IDLE;
      fpc_q   <= {RESET_PC[31:2], 2'b00};
      dpc_q   <= {RESET_PC[31:2], 2'b00};
      pc_q    <= RESET_PC;
      instr_q <= '{opcode: OPCODE_NOP, operand: 26'b0};
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      dpc_q   <= dpc_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ov_q    <= ov_d;
    end
  end

  assign ibus_req  = (state_q == IF_REQ) || (state_q == IF_DISCARD);
  assign ibus_addr = (state_q == IF_DISCARD) ? dpc_q : fpc_q;
  assign if_pc     = pc_q;
  assign if_instr  = instr_q;
  assign if_busy   = ~ov_q | id_halt;

endmodule

// File: tb/tb_core_if.sv
// tb/tb_core_if.sv - self-checking bench for core_if against a transaction-level fetch model

import i2d_core_defines::*;

module tb_core_if;

  localparam logic [31:0] RST_PC   = 32'h0000_0100;
  localparam logic [31:0] NOP_WORD = {OPCODE_NOP, 26'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        id_halt;
  logic        flush;
  logic [31:0] branch_pc;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_busy;

  int n_asserts = 0;
  int n_fail    = 0;

  core_if #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_halt    (id_halt),
    .flush      (flush),
    .branch_pc  (branch_pc),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_busy    (if_busy)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: fetch pointer, presented slot, and a queue of
  // addresses already on the bus whose data must be thrown away.
  logic [31:0] m_fpc;
  logic        m_sv;
  logic [31:0] m_spc;
  logic [31:0] m_sinstr;
  logic        m_idle;
  logic        m_wait;
  logic [31:0] m_drop[$];
  logic        m_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic a, input logic h,
                              input logic f, input logic [31:0] bp);
    logic        consumed;
    logic        req_now;
    logic [31:0] dummy;
    if (r) begin
      m_fpc    = {RST_PC[31:2], 2'b00};
      m_sv     = 1'b0;
      m_spc    = RST_PC;
      m_sinstr = NOP_WORD;
      m_idle   = 1'b1;
      m_wait   = 1'b0;
      m_drop.delete();
      m_known  = 1'b1;
      return;
    end
    consumed = m_sv && !h;
    req_now  = !m_idle && !m_wait;
    if (f) begin
      if (m_drop.size() > 0) begin
        if (a) dummy = m_drop.pop_front();
      end else if (req_now && !a) begin
        m_drop.push_back(m_fpc);
      end
      m_sv   = 1'b0;
      m_fpc  = {bp[31:2], 2'b00};
      m_idle = 1'b0;
      m_wait = 1'b0;
      return;
    end
    if (m_idle) begin
      m_idle = 1'b0;
      return;
    end
    if (m_wait) begin
      if (consumed) begin
        m_sv   = 1'b0;
        m_wait = 1'b0;
      end
      return;
    end
    if (m_drop.size() > 0) begin
      if (a) dummy = m_drop.pop_front();
      return;
    end
    if (m_sv && h) begin
      m_wait = 1'b1;
      return;
    end
    if (a) begin
      m_spc    = m_fpc;
      m_sinstr = mem(m_fpc);
      m_sv     = 1'b1;
      m_fpc    = m_fpc + 32'd4;
    end else if (consumed) begin
      m_sv = 1'b0;
    end
  endtask

  // Called on a falling edge: drive inputs, check outputs, advance model, next falling edge.
  task automatic step(input logic r, input logic a, input logic h,
                      input logic f, input logic [31:0] bp);
    logic        e_req;
    logic [31:0] e_addr;
    rst        = r;
    ibus_ack   = a;
    id_halt    = h;
    flush      = f;
    branch_pc  = bp;
    ibus_rdata = mem(ibus_addr);
    #1;
    if (m_known) begin
      e_req  = !m_idle && !m_wait;
      e_addr = (m_drop.size() > 0) ? m_drop[0] : m_fpc;
      chk("ibus_req", {31'b0, ibus_req}, {31'b0, e_req});
      if (e_req) chk("ibus_addr", ibus_addr, e_addr);
      chk("if_busy", {31'b0, if_busy}, {31'b0, (!m_sv || h)});
      if (m_sv) begin
        chk("if_pc", if_pc, m_spc);
        chk("if_instr", if_instr, m_sinstr);
      end
    end
    model_update(r, a, h, f, bp);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    id_halt    = 1'b0;
    flush      = 1'b0;
    branch_pc  = 32'h0;
    ibus_ack   = 1'b0;
    ibus_rdata = 32'h0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    chk("rst_req", {31'b0, ibus_req}, 32'd0);
    chk("rst_busy", {31'b0, if_busy}, 32'd1);
    chk("rst_instr", if_instr, NOP_WORD);
    chk("rst_pc", if_pc, 32'h100);

    // Streaming with ack tied high
    step(0, 1, 0, 0, 32'h0);
    chk("seq_a0", ibus_addr, 32'h100);
    step(0, 1, 0, 0, 32'h0);
    chk("seq_a1", ibus_addr, 32'h104);
    chk("seq_pc0", if_pc, 32'h100);
    chk("seq_busy0", {31'b0, if_busy}, 32'd0);
    step(0, 1, 0, 0, 32'h0);
    chk("seq_a2", ibus_addr, 32'h108);
    chk("seq_pc1", if_pc, 32'h104);

    // Three-cycle decode stall at if_pc=0x104
    step(0, 1, 1, 0, 32'h0);
    chk("halt_req", {31'b0, ibus_req}, 32'd0);
    step(0, 1, 1, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    chk("halt_pc", if_pc, 32'h104);
    step(0, 1, 0, 0, 32'h0);
    chk("resume_addr", ibus_addr, 32'h108);
    step(0, 1, 0, 0, 32'h0);
    chk("resume_pc", if_pc, 32'h108);
    chk("resume_instr", if_instr, mem(32'h108));

    // Flush while ack is delayed: old address held, its data dropped
    step(0, 0, 0, 1, 32'h203);
    chk("disc_addr0", ibus_addr, 32'h10C);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    chk("disc_addr3", ibus_addr, 32'h10C);
    step(0, 1, 0, 0, 32'h0);
    chk("disc_next", ibus_addr, 32'h200);
    chk("disc_busy", {31'b0, if_busy}, 32'd1);
    step(0, 1, 0, 0, 32'h0);
    chk("disc_pc", if_pc, 32'h200);

    // Flush together with ack and halt
    step(0, 1, 1, 1, 32'h3002);
    chk("fah_addr", ibus_addr, 32'h3000);
    id_halt = 1'b0;
    #1;
    chk("fah_busy", {31'b0, if_busy}, 32'd1);

    // Fetch pointer wrap at the top of the address space
    step(0, 1, 0, 1, 32'hFFFF_FFFE);
    chk("wrap_a0", ibus_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 32'h0);
    chk("wrap_a1", ibus_addr, 32'h0000_0000);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);

    // Reset with a request outstanding
    step(0, 0, 0, 0, 32'h0);
    chk("rreq_pend", {31'b0, ibus_req}, 32'd1);
    step(1, 1, 0, 0, 32'h0);
    chk("rreq_req", {31'b0, ibus_req}, 32'd0);
    chk("rreq_instr", if_instr, NOP_WORD);
    chk("rreq_busy", {31'b0, if_busy}, 32'd1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 8),
           $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
